// File: rtl/interval_meter_pkg.sv
// Shared definitions for the interval meter:
// FSM state codes and default count geometry.
package interval_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 14;
  localparam int DEF_MAX   = 9999;

endpackage

// File: rtl/interval_meter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; increment at MAX is a no-op.
module sat_counter
  import interval_meter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX   = DEF_MAX
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  assign at_max = (q == MAXV);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/interval_meter.sv
// Counts time-base ticks between start and stop events;
// the result saturates at MAX and is flagged valid/overflow.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX   = DEF_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             valid,
  output logic             overflow
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   valid_q, valid_d;
  logic   ovf_q, ovf_d;
  logic   clr, inc, at_max;

  sat_counter #(
    .WIDTH(WIDTH),
    .MAX  (MAX)
  ) u_cnt (
    .clk   (clk),
    .clr   (clr | rst),
    .inc   (inc),
    .q     (count),
    .at_max(at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          clr     = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        // a tick arriving at MAX overflows even if stop is also seen
        if (tick && at_max) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          inc = tick;
          if (stop) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            ovf_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        clr     = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: default MAX=9999 and small MAX=15
// instances share stimulus and are checked against a tick model.
module tb_interval_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] count_a;
  logic        busy_a, valid_a, ovf_a;
  logic [3:0]  count_b;
  logic        busy_b, valid_b, ovf_b;

  int checks = 0;
  int errors = 0;

  bit m_run[2];
  bit m_done[2];
  bit m_ovf[2];
  int m_cnt[2];
  int m_max[2] = '{9999, 15};

  always #5 clk = ~clk;

  interval_meter dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .count(count_a), .busy(busy_a), .valid(valid_a), .overflow(ovf_a)
  );

  interval_meter #(.WIDTH(4), .MAX(15)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .count(count_b), .busy(busy_b), .valid(valid_b), .overflow(ovf_b)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A measurement is "ticks seen while running", capped at MAX;
  // a tick arriving when already at MAX ends it as an overflow.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
      end else if (!m_run[i]) begin
        if (start) begin
          m_run[i] = 1; m_done[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
        end
      end else begin
        if (tick) begin
          if (m_cnt[i] >= m_max[i]) begin
            m_run[i] = 0; m_done[i] = 1; m_ovf[i] = 1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (stop && m_run[i]) begin
          m_run[i] = 0; m_done[i] = 1; m_ovf[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("cnt_a",  32'(count_a), 32'(m_cnt[0]));
    chk("busy_a", 32'(busy_a),  32'(m_run[0]));
    chk("vld_a",  32'(valid_a), 32'(m_done[0]));
    chk("ovf_a",  32'(ovf_a),   32'(m_ovf[0]));
    chk("cnt_b",  32'(count_b), 32'(m_cnt[1]));
    chk("busy_b", 32'(busy_b),  32'(m_run[1]));
    chk("vld_b",  32'(valid_b), 32'(m_done[1]));
    chk("ovf_b",  32'(ovf_b),   32'(m_ovf[1]));
  endtask

  task automatic step(bit r, bit s, bit p, bit t);
    @(negedge clk);
    rst = r; start = s; stop = p; tick = t;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_cnt", 32'(count_a), 0);
    chk("rst_busy", 32'(busy_a), 0);

    // reset mid-run aborts without result
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rr_cnt", 32'(count_a), 0);
    chk("rr_busy", 32'(busy_a), 0);
    chk("rr_vld", 32'(valid_a), 0);
    chk("rr_ovf", 32'(ovf_a), 0);
    step(0, 0, 0, 0);

    // basic: 25 ticks every 4th clock
    step(0, 1, 0, 0);
    for (int i = 0; i < 25; i++) begin
      step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 0, 0, 1);
    end
    step(0, 0, 1, 0);
    chk("basic_cnt", 32'(count_a), 25);
    chk("basic_vld", 32'(valid_a), 1);
    chk("basic_ovf", 32'(ovf_a), 0);
    chk("basic_busy", 32'(busy_a), 0);

    // simultaneous stop+tick after 7 ticks
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("sim_cnt", 32'(count_a), 8);
    chk("sim_vld", 32'(valid_a), 1);

    // saturate the MAX=15 instance
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1);
    chk("sat_cnt", 32'(count_b), 15);
    chk("sat_ovf", 32'(ovf_b), 1);
    chk("sat_vld", 32'(valid_b), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("sat_hold", 32'(count_b), 15);
    chk("sat_ovf2", 32'(ovf_b), 1);
    chk("sat_a_cnt", 32'(count_a), 20);

    // reaching MAX together with stop is not an overflow
    step(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("edge_cnt", 32'(count_b), 15);
    chk("edge_ovf", 32'(ovf_b), 0);

    // ignored inputs
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("ign_idle", 32'(busy_a), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("ign_run", 32'(count_a), 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("ign_done", 32'(count_a), 1);
    chk("ign_vld", 32'(valid_a), 1);
    step(0, 1, 0, 0);
    chk("rs_cnt", 32'(count_a), 0);
    chk("rs_vld", 32'(valid_a), 0);
    chk("rs_busy", 32'(busy_a), 1);

    // start and stop together from IDLE
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("b2b_busy", 32'(busy_a), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("b2b_cnt", 32'(count_a), 3);

    // saturate the default instance; final tick coincides with stop
    step(0, 1, 0, 0);
    for (int i = 0; i < 9999; i++) step(0, 0, 0, 1);
    chk("big_cnt", 32'(count_a), 9999);
    chk("big_busy", 32'(busy_a), 1);
    step(0, 0, 1, 1);
    chk("big_ovf", 32'(ovf_a), 1);
    chk("big_hold", 32'(count_a), 9999);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 24) == 0,
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
